// File: rtl/rr_bus_arbiter_if.sv
// Bus-request interface between the requester blocks and rr_bus_arbiter.
// The master modport is the arbiter side; slave is the requester/bus-mux side.
interface rr_bus_arbiter_if #(
   parameter int N   = 8,
   parameter int IDW = 3
);
   logic [N-1:0]   Req;
   logic [N-1:0]   Gnt;
   logic [IDW-1:0] GntId;
   logic           Busy;
   logic           TimeoutErr;

   modport master (
      input  Req,
      output Gnt,
      output GntId,
      output Busy,
      output TimeoutErr
   );

   modport slave (
      output Req,
      input  Gnt,
      input  GntId,
      input  Busy,
      input  TimeoutErr
   );
endinterface

// File: rtl/rr_bus_arbiter.sv
// Round-robin arbiter for the MiniComputer system bus: IDLE -> ARB -> GRANT -> RELEASE.
// Optional forced release after MAX_HOLD grant cycles is enabled by macro RR_ARB_TIMEOUT_EN.
module rr_bus_arbiter #(
   parameter int N        = 8,
   parameter int IDW      = 3,
   parameter int MAX_HOLD = 16,
   parameter int HOLDW    = 5
) (
   input logic              Clk,
   input logic              Rst,
   rr_bus_arbiter_if.master bus
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ARB     = 2'd1;
   localparam logic [1:0] ST_GRANT   = 2'd2;
   localparam logic [1:0] ST_RELEASE = 2'd3;

   localparam logic [N-1:0]   GNT_ONE = {{(N-1){1'b0}}, 1'b1};
   localparam logic [IDW-1:0] ID_ONE  = {{(IDW-1){1'b0}}, 1'b1};
   localparam logic [IDW-1:0] ID_LAST = IDW'(N - 1);
   localparam logic [IDW:0]   N_W     = (IDW + 1)'(N);

   // Reject configurations where GntId or the hold counter cannot cover its range.
   if (N < 2 || (1 << IDW) < N || (1 << HOLDW) <= MAX_HOLD) begin : g_bad_cfg
      $error("rr_bus_arbiter: inconsistent N/IDW/MAX_HOLD/HOLDW");
   end

   logic [1:0]     state_r, state_nx_s;
   logic [N-1:0]   gnt_r, gnt_nx_s;
   logic [IDW-1:0] id_r, id_nx_s;
   logic [IDW-1:0] ptr_r, ptr_nx_s;
   logic           busy_r, busy_nx_s;

   logic           found_s;
   logic [IDW-1:0] win_s;
   logic [IDW:0]   idx_s;
   logic [IDW-1:0] ptr_after_s;

`ifdef RR_ARB_TIMEOUT_EN
   localparam logic [HOLDW-1:0] HOLD_ONE  = {{(HOLDW-1){1'b0}}, 1'b1};
   localparam logic [HOLDW-1:0] HOLD_SAT  = HOLDW'(MAX_HOLD);
   localparam logic [HOLDW-1:0] HOLD_LAST = HOLDW'(MAX_HOLD - 1);

   logic [HOLDW-1:0] hold_r, hold_nx_s;
   logic             terr_r, terr_nx_s;
`endif

   // Rotating priority search: first set Req bit at or above ptr_r, wrapping to 0.
   always_comb begin
      found_s = 1'b0;
      win_s   = ptr_r;
      idx_s   = {IDW+1{1'b0}};
      for (int k = 0; k < N; k++) begin
         idx_s = {1'b0, ptr_r} + (IDW + 1)'(k);
         if (idx_s >= N_W) begin
            idx_s = idx_s - N_W;
         end else begin
            idx_s = idx_s;
         end
         if (!found_s && bus.Req[idx_s[IDW-1:0]]) begin
            found_s = 1'b1;
            win_s   = idx_s[IDW-1:0];
         end else begin
            found_s = found_s;
         end
      end
   end

   assign ptr_after_s = (id_r == ID_LAST) ? {IDW{1'b0}} : id_r + ID_ONE;

   // Next-state and next-output computation for the arbitration FSM.
   always_comb begin
      state_nx_s = state_r;
      gnt_nx_s   = gnt_r;
      id_nx_s    = id_r;
      ptr_nx_s   = ptr_r;
      busy_nx_s  = busy_r;
`ifdef RR_ARB_TIMEOUT_EN
      hold_nx_s  = hold_r;
      terr_nx_s  = 1'b0;
`endif
      case (state_r)
         ST_IDLE: begin
            gnt_nx_s  = {N{1'b0}};
            busy_nx_s = 1'b0;
            if (|bus.Req) begin
               state_nx_s = ST_ARB;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_ARB: begin
            if (found_s) begin
               state_nx_s = ST_GRANT;
               gnt_nx_s   = GNT_ONE << win_s;
               id_nx_s    = win_s;
               busy_nx_s  = 1'b1;
`ifdef RR_ARB_TIMEOUT_EN
               hold_nx_s  = {HOLDW{1'b0}};
`endif
            end else begin
               // Request vanished before it could be served; Ptr is left alone.
               state_nx_s = ST_IDLE;
               gnt_nx_s   = {N{1'b0}};
               busy_nx_s  = 1'b0;
            end
         end
         ST_GRANT: begin
            if (!bus.Req[id_r]) begin
               state_nx_s = ST_RELEASE;
               gnt_nx_s   = {N{1'b0}};
               busy_nx_s  = 1'b0;
               ptr_nx_s   = ptr_after_s;
`ifdef RR_ARB_TIMEOUT_EN
            end else if (hold_r == HOLD_LAST) begin
               state_nx_s = ST_RELEASE;
               gnt_nx_s   = {N{1'b0}};
               busy_nx_s  = 1'b0;
               ptr_nx_s   = ptr_after_s;
               terr_nx_s  = 1'b1;
            end else begin
               state_nx_s = ST_GRANT;
               if (hold_r == HOLD_SAT) begin
                  hold_nx_s = hold_r;
               end else begin
                  hold_nx_s = hold_r + HOLD_ONE;
               end
            end
`else
            end else begin
               state_nx_s = ST_GRANT;
            end
`endif
         end
         ST_RELEASE: begin
            gnt_nx_s  = {N{1'b0}};
            busy_nx_s = 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
            hold_nx_s = {HOLDW{1'b0}};
`endif
            if (|bus.Req) begin
               state_nx_s = ST_ARB;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         default: begin
            state_nx_s = ST_IDLE;
            gnt_nx_s   = {N{1'b0}};
            busy_nx_s  = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         state_r <= ST_IDLE;
         gnt_r   <= {N{1'b0}};
         id_r    <= {IDW{1'b0}};
         ptr_r   <= {IDW{1'b0}};
         busy_r  <= 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
         hold_r  <= {HOLDW{1'b0}};
         terr_r  <= 1'b0;
`endif
      end else begin
         state_r <= state_nx_s;
         gnt_r   <= gnt_nx_s;
         id_r    <= id_nx_s;
         ptr_r   <= ptr_nx_s;
         busy_r  <= busy_nx_s;
`ifdef RR_ARB_TIMEOUT_EN
         hold_r  <= hold_nx_s;
         terr_r  <= terr_nx_s;
`endif
      end
   end

   assign bus.Gnt   = gnt_r;
   assign bus.GntId = id_r;
   assign bus.Busy  = busy_r;
`ifdef RR_ARB_TIMEOUT_EN
   assign bus.TimeoutErr = terr_r;
`else
   assign bus.TimeoutErr = 1'b0;
`endif

endmodule
